// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame width, bit-counter width, FSM state encoding
// and a shift helper used by both the slave and the companion master.
package spi_pkg;

    localparam int SPI_BITS = 8;
    localparam int CNT_W    = $clog2(SPI_BITS);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    function automatic logic [SPI_BITS-1:0] shift_in(input logic [SPI_BITS-1:0] cur,
                                                     input logic                bit_in);
        return {cur[SPI_BITS-2:0], bit_in};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// taken from the last stage against one extra delayed flop.
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // synchronizer chain plus edge-detect delay flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~dly_q;
    assign fall_o = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, oversampled in the clk domain. Received
// bytes pulse out on rx_valid; transmit bytes come from a 1-entry holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [SPI_BITS-1:0] UNDERRUN_BYTE = 8'h00
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                tx_underrun,
    output logic                frame_err,
    input  logic                sck,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe
);

    logic sck_s, sck_rise_s, sck_fall_s;
    logic cs_s, cs_rise_s, cs_fall_s;
    logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (sck),
        .q_o    (sck_s),
        .rise_o (sck_rise_s),
        .fall_o (sck_fall_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (cs_n),
        .q_o    (cs_s),
        .rise_o (cs_rise_s),
        .fall_o (cs_fall_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_unused_s),
        .fall_o (mosi_fall_unused_s)
    );

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;
    logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
    logic [SPI_BITS-1:0] hold_q, hold_d;
    logic                tx_ready_q, tx_ready_d;
    logic                rx_valid_q, rx_valid_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                frame_err_q, frame_err_d;
    logic                miso_q, miso_d;
    logic                load_s;
    logic [SPI_BITS-1:0] rx_byte_s;

    // FSM next-state, shift registers, load points and holding register
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        rx_data_d     = rx_data_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_err_d   = 1'b0;
        miso_d        = miso_q;
        load_s        = 1'b0;
        rx_byte_s     = shift_in(rx_shift_q, mosi_s);

        case (state_q)
            S_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = S_ACTIVE;
                    bit_cnt_d = {CNT_W{1'b0}};
                    load_s    = 1'b1;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_ACTIVE: begin
                // a deselect wins over any sck edge seen in the same cycle
                if (cs_rise_s) begin
                    state_d     = S_IDLE;
                    miso_d      = 1'b0;
                    bit_cnt_d   = {CNT_W{1'b0}};
                    rx_shift_d  = {SPI_BITS{1'b0}};
                    tx_shift_d  = {SPI_BITS{1'b0}};
                    frame_err_d = (bit_cnt_q != {CNT_W{1'b0}});
                end else if (sck_rise_s) begin
                    rx_shift_d = rx_byte_s;
                    bit_cnt_d  = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bit_cnt_q == CNT_W'(SPI_BITS - 1)) begin
                        rx_data_d  = rx_byte_s;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sck_fall_s) begin
                    // bit_cnt back at zero means this fall closes a whole byte
                    if (bit_cnt_q == {CNT_W{1'b0}}) begin
                        load_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
                        miso_d     = tx_shift_q[SPI_BITS-2];
                    end
                end else begin
                    state_d = S_ACTIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_s) begin
            if (!tx_ready_q) begin
                tx_shift_d = hold_q;
                tx_ready_d = 1'b1;
            end else begin
                tx_shift_d    = UNDERRUN_BYTE;
                tx_underrun_d = 1'b1;
            end
            miso_d = tx_shift_d[SPI_BITS-1];
        end else begin
            load_s = 1'b0;
        end

        // holding state is judged on the start-of-cycle value, so a write in a
        // load cycle lands for the following byte
        if (tx_valid && tx_ready_q) begin
            hold_d     = tx_data;
            tx_ready_d = 1'b0;
        end else begin
            hold_d = hold_d;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= {CNT_W{1'b0}};
            rx_shift_q    <= {SPI_BITS{1'b0}};
            tx_shift_q    <= {SPI_BITS{1'b0}};
            rx_data_q     <= {SPI_BITS{1'b0}};
            hold_q        <= {SPI_BITS{1'b0}};
            tx_ready_q    <= 1'b1;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            rx_data_q     <= rx_data_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_err_q   <= frame_err_d;
            miso_q        <= miso_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign busy        = (state_q == S_ACTIVE);
    assign miso_oe     = (state_q == S_ACTIVE);
    assign tx_underrun = tx_underrun_q;
    assign frame_err   = frame_err_q;
    assign miso        = miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives sck/cs_n/mosi
// with half-period 4 clk and compares against hand-computed bytes and pulse counts.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_err;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;

    int n_cmp = 0;
    int n_err = 0;
    int rx_n = 0;
    int und_n = 0;
    int fe_n = 0;
    logic [7:0] rx_log [0:31];

    spi_slave dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err),
        .sck         (sck),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    always #5 clk = ~clk;

    // pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_n[4:0]] = rx_data;
            rx_n = rx_n + 1;
        end
        if (tx_underrun) und_n = und_n + 1;
        if (frame_err)   fe_n  = fe_n + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] b);
        int k = 0;
        while (!tx_ready && k < 60) begin
            tick(1);
            k = k + 1;
        end
        check("tx_ready_wait", {7'd0, tx_ready}, 8'h01);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    // last: final sck fall coincides with cs_n rise, ending the frame
    task automatic send_bits(input logic [7:0] mo, input int nbits, input bit last,
                             output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            tick(4);
            sck   = 1'b1;
            mi[i] = miso;
            tick(4);
            sck = 1'b0;
            if (last && i == 7 - nbits + 1) cs_n = 1'b1;
        end
    endtask

    logic [7:0] mi0, mi1, mi2;
    int rx0, und0, fe0;

    initial begin
        // reset state
        tick(3);
        check("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        check("rst_miso", {6'd0, miso_oe, miso}, 8'h00);
        check("rst_pulses", {5'd0, rx_valid, tx_underrun, frame_err}, 8'h00);
        rst_n = 1'b1;
        tick(4);

        // 1: preloaded A5 out, 3C in
        rx0 = rx_n; und0 = und_n;
        write_tx(8'hA5);
        check("t1_ready_low", {7'd0, tx_ready}, 8'h00);
        cs_n = 1'b0;
        tick(4);
        check("t1_busy", {6'd0, busy, miso_oe}, 8'h03);
        send_bits(8'h3C, 8, 1'b1, mi0);
        tick(8);
        check("t1_miso", mi0, 8'hA5);
        check("t1_rx_cnt", 8'(rx_n - rx0), 8'd1);
        check("t1_rx_data", rx_data, 8'h3C);
        check("t1_rx_log", rx_log[rx0[4:0]], 8'h3C);
        check("t1_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("t1_underrun", 8'(und_n - und0), 8'd0);
        check("t1_idle", {6'd0, busy, miso_oe}, 8'h00);

        // 2: three bytes in one frame
        rx0 = rx_n; und0 = und_n;
        write_tx(8'h10);
        cs_n = 1'b0;
        write_tx(8'h20);
        tick(4);
        send_bits(8'h01, 8, 1'b0, mi0);
        write_tx(8'h30);
        send_bits(8'h02, 8, 1'b0, mi1);
        send_bits(8'h03, 8, 1'b1, mi2);
        tick(8);
        check("t2_miso0", mi0, 8'h10);
        check("t2_miso1", mi1, 8'h20);
        check("t2_miso2", mi2, 8'h30);
        check("t2_rx_cnt", 8'(rx_n - rx0), 8'd3);
        check("t2_rx0", rx_log[rx0[4:0]], 8'h01);
        check("t2_rx1", rx_log[5'(rx0 + 1)], 8'h02);
        check("t2_rx2", rx_log[5'(rx0 + 2)], 8'h03);
        check("t2_underrun", 8'(und_n - und0), 8'd0);

        // 3: underrun
        rx0 = rx_n; und0 = und_n;
        cs_n = 1'b0;
        tick(4);
        check("t3_und_at_cs", 8'(und_n - und0), 8'd1);
        send_bits(8'hFF, 8, 1'b1, mi0);
        tick(8);
        check("t3_miso", mi0, 8'h00);
        check("t3_und_total", 8'(und_n - und0), 8'd1);
        check("t3_rx_data", rx_data, 8'hFF);

        // 4: partial byte, then recovery
        rx0 = rx_n; fe0 = fe_n;
        cs_n = 1'b0;
        tick(4);
        send_bits(8'hAA, 5, 1'b0, mi0);
        tick(4);
        cs_n = 1'b1;
        tick(8);
        check("t4_frame_err", 8'(fe_n - fe0), 8'd1);
        check("t4_no_rx", 8'(rx_n - rx0), 8'd0);
        check("t4_rx_kept", rx_data, 8'hFF);
        cs_n = 1'b0;
        tick(4);
        send_bits(8'h5A, 8, 1'b1, mi0);
        tick(8);
        check("t4_rx_next", rx_data, 8'h5A);
        check("t4_rx_cnt", 8'(rx_n - rx0), 8'd1);
        check("t4_fe_total", 8'(fe_n - fe0), 8'd1);

        // 5: reset mid-byte
        write_tx(8'hFF);
        cs_n = 1'b0;
        tick(4);
        send_bits(8'h00, 3, 1'b0, mi0);
        tick(2);
        rst_n = 1'b0;
        #1;
        check("t5_tx_ready", {7'd0, tx_ready}, 8'h01);
        check("t5_rx_data", rx_data, 8'h00);
        check("t5_busy", {6'd0, busy, miso_oe}, 8'h00);
        check("t5_miso", {7'd0, miso}, 8'h00);
        check("t5_pulses", {5'd0, rx_valid, tx_underrun, frame_err}, 8'h00);
        cs_n = 1'b1;
        tick(4);
        rst_n = 1'b1;
        tick(4);
        rx0 = rx_n;
        write_tx(8'h96);
        cs_n = 1'b0;
        tick(4);
        send_bits(8'hC3, 8, 1'b1, mi0);
        tick(8);
        check("t5_miso_after", mi0, 8'h96);
        check("t5_rx_after", rx_data, 8'hC3);
        check("t5_rx_cnt", 8'(rx_n - rx0), 8'd1);

        // 6: write in the exact load cycle with holding empty
        rx0 = rx_n; und0 = und_n;
        cs_n = 1'b0;
        tick(2);
        tx_data  = 8'h77;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(1);
        check("t6_und_load", 8'(und_n - und0), 8'd1);
        check("t6_held", {7'd0, tx_ready}, 8'h00);
        send_bits(8'h11, 8, 1'b0, mi0);
        send_bits(8'h22, 8, 1'b1, mi1);
        tick(8);
        check("t6_miso0", mi0, 8'h00);
        check("t6_miso1", mi1, 8'h77);
        check("t6_und_total", 8'(und_n - und0), 8'd1);
        check("t6_rx0", rx_log[rx0[4:0]], 8'h11);
        check("t6_rx1", rx_log[5'(rx0 + 1)], 8'h22);
        check("t6_tx_ready", {7'd0, tx_ready}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
